// File: rtl/vstore_serializer.sv
// Vector store serializer: streams one VLEN-bit store operand into an ELEN-bit
// data memory write port, one element per accepted transfer.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start_valid/ready       request handshake (ready only while idle)
//   vs3, base_addr          store data and byte address of element 0
//   stride_en, stride       0: unit stride (ELEN/8 bytes), 1: signed byte stride
//   vmask, vl               per-element enable and active element count
//   mem_we/addr/wdata/be    write request, held stable until mem_ready
//   mem_ready               memory accepts the write this cycle
//   busy, done              request in progress / one-cycle completion pulse
//   err_misaligned          alignment fault, pulses together with done
module vstore_serializer #(
  parameter int unsigned VLEN            = 128,
  parameter int unsigned ELEN            = 32,
  parameter int unsigned DATA_ADDR_WIDTH = 10,
  localparam int unsigned NLANES         = VLEN / ELEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [VLEN-1:0]              vs3,
  input  logic [DATA_ADDR_WIDTH-1:0]   base_addr,
  input  logic                         stride_en,
  input  logic [31:0]                  stride,
  input  logic [NLANES-1:0]            vmask,
  input  logic [$clog2(NLANES):0]      vl,
  output logic                         mem_we,
  output logic [DATA_ADDR_WIDTH-1:0]   mem_addr,
  output logic [ELEN-1:0]              mem_wdata,
  output logic [ELEN/8-1:0]            mem_be,
  input  logic                         mem_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         err_misaligned
);

  localparam int unsigned LaneW  = $clog2(NLANES);
  localparam int unsigned VlW    = LaneW + 1;
  localparam int unsigned BeW    = ELEN / 8;
  localparam int unsigned AlignW = $clog2(BeW);
  localparam int unsigned AW     = DATA_ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e                       state_q, state_d;
  logic [NLANES-1:0][ELEN-1:0]  data_q, data_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic [31:0]                  stride_q, stride_d;
  logic [NLANES-1:0]            vmask_q, vmask_d;
  logic [VlW-1:0]               vl_q, vl_d;
  logic [LaneW-1:0]             lane_q, lane_d;
  logic                         err_q, err_d;

  logic                         lane_active;
  logic                         last_lane;
  logic [VlW-1:0]               vl_last;
  logic                         misaligned;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    vmask_d  = vmask_q;
    vl_d     = vl_q;
    lane_d   = lane_q;
    err_d    = err_q;

    lane_active = vmask_q[lane_q];
    vl_last     = vl_q - VlW'(1);
    last_lane   = ({1'b0, lane_q} == vl_last);
    misaligned  = (base_addr[AlignW-1:0] != '0) || (stride_en && (stride[AlignW-1:0] != '0));

    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          data_d   = vs3;
          addr_d   = base_addr;
          stride_d = stride_en ? stride : 32'(BeW);
          vmask_d  = vmask;
          vl_d     = (vl > VlW'(NLANES)) ? VlW'(NLANES) : vl;
          lane_d   = '0;
          err_d    = misaligned;
          // Faults and empty requests complete without touching memory.
          state_d  = (misaligned || (vl == '0)) ? StDone : StIssue;
        end
      end
      StIssue: begin
        // Masked lanes advance unconditionally; active lanes wait for accept.
        if (!lane_active || mem_ready) begin
          lane_d = lane_q + LaneW'(1);
          // Address wraps modulo 2^AW; negative strides fall out of the truncation.
          addr_d = AW'(32'(addr_q) + stride_q);
          if (last_lane) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      data_q   <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      vmask_q  <= '0;
      vl_q     <= '0;
      lane_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      vmask_q  <= vmask_d;
      vl_q     <= vl_d;
      lane_q   <= lane_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    start_ready    = (state_q == StIdle);
    busy           = (state_q != StIdle);
    mem_we         = (state_q == StIssue) && vmask_q[lane_q];
    mem_addr       = mem_we ? addr_q : '0;
    mem_wdata      = mem_we ? data_q[lane_q] : '0;
    mem_be         = {BeW{mem_we}};
    done           = (state_q == StDone);
    err_misaligned = (state_q == StDone) && err_q;
  end

endmodule

// File: tb/tb_vstore_serializer.sv
// Self-checking bench for vstore_serializer: directed cases plus randomized
// requests checked against a queue-based reference of the expected writes.
module tb_vstore_serializer;

  localparam int VLEN = 128;
  localparam int ELEN = 32;
  localparam int AW   = 10;
  localparam int NL   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_valid;
  logic              start_ready;
  logic [VLEN-1:0]   vs3;
  logic [AW-1:0]     base_addr;
  logic              stride_en;
  logic [31:0]       stride;
  logic [NL-1:0]     vmask;
  logic [2:0]        vl;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [ELEN-1:0]   mem_wdata;
  logic [ELEN/8-1:0] mem_be;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              err_misaligned;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vstore_serializer #(
    .VLEN            (VLEN),
    .ELEN            (ELEN),
    .DATA_ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .vs3            (vs3),
    .base_addr      (base_addr),
    .stride_en      (stride_en),
    .stride         (stride),
    .vmask          (vmask),
    .vl             (vl),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_ready      (mem_ready),
    .busy           (busy),
    .done           (done),
    .err_misaligned (err_misaligned)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to completion. stall = cycles mem_ready
  // is held low before each active word is accepted.
  task automatic run_req(input string name, input logic [127:0] v, input logic [AW-1:0] base,
                         input logic sen, input logic [31:0] str, input logic [NL-1:0] msk,
                         input logic [2:0] vl_in, input int stall);
    logic [AW-1:0]   eaddr[$];
    logic [ELEN-1:0] edata[$];
    logic            eerr;
    int              vle;
    int              seff;
    int              done_cycle;
    int              wait_cnt;
    bit              seen_done;

    // Reference: element i lands at (base + i*stride) mod 2^AW if enabled.
    vle        = (int'(vl_in) > NL) ? NL : int'(vl_in);
    seff       = sen ? $signed(str) : ELEN / 8;
    eerr       = (base[1:0] != 2'b00) || (sen && (str[1:0] != 2'b00));
    done_cycle = 1;
    if (!eerr) begin
      for (int i = 0; i < vle; i++) begin
        if (msk[i]) begin
          eaddr.push_back(AW'(int'(base) + i * seff));
          edata.push_back(ELEN'(v >> (ELEN * i)));
          done_cycle += stall + 1;
        end else begin
          done_cycle += 1;
        end
      end
    end

    @(negedge clk);
    check({name, " start_ready_idle"}, start_ready, 1);
    start_valid = 1'b1;
    vs3         = v;
    base_addr   = base;
    stride_en   = sen;
    stride      = str;
    vmask       = msk;
    vl          = vl_in;
    mem_ready   = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    // Scramble request inputs; the engine must work from its latched copy.
    vs3       = {$urandom, $urandom, $urandom, $urandom};
    base_addr = AW'($urandom);
    stride    = $urandom;
    vmask     = NL'($urandom);
    vl        = 3'($urandom);
    stride_en = 1'($urandom);

    wait_cnt  = 0;
    seen_done = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      if (done) begin
        check({name, " done_cycle"}, cyc, done_cycle);
        check({name, " err"}, err_misaligned, eerr);
        check({name, " writes_left"}, eaddr.size(), 0);
        seen_done = 1'b1;
        mem_ready = 1'b0;
        break;
      end
      check({name, " busy"}, busy, 1);
      check({name, " start_ready_busy"}, start_ready, 0);
      if (mem_we) begin
        if (eaddr.size() == 0) begin
          check({name, " unexpected_write"}, mem_we, 0);
          mem_ready = 1'b1;
        end else begin
          check({name, " addr"}, mem_addr, eaddr[0]);
          check({name, " wdata"}, mem_wdata, edata[0]);
          check({name, " be"}, mem_be, 4'hF);
          if (wait_cnt == stall) begin
            mem_ready = 1'b1;
            void'(eaddr.pop_front());
            void'(edata.pop_front());
            wait_cnt = 0;
          end else begin
            mem_ready = 1'b0;
            wait_cnt++;
          end
        end
      end else begin
        check({name, " be_idle"}, mem_be, 0);
        // mem_ready without mem_we must have no effect.
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    if (!seen_done) check({name, " timeout"}, seen_done, 1);

    @(negedge clk);
    check({name, " post_ready"}, start_ready, 1);
    check({name, " post_busy"}, busy, 0);
    check({name, " post_done"}, done, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    vs3         = '1;
    base_addr   = '1;
    stride_en   = 1'b0;
    stride      = '0;
    vmask       = '1;
    vl          = 3'd4;
    mem_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst start_ready", start_ready, 1);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst mem_be", mem_be, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err_misaligned, 0);
    rst_n     = 1'b1;
    mem_ready = 1'b0;

    run_req("unit", 128'h44444444_33333333_22222222_11111111, 10'h040, 1'b0, 32'd0,
            4'b1111, 3'd4, 0);
    run_req("stride_bp", 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 10'h020, 1'b1, -32'sd8,
            4'b1111, 3'd3, 2);
    run_req("mask", 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 10'h100, 1'b0, 32'd0,
            4'b1010, 3'd4, 0);
    run_req("misalign", 128'h1, 10'h102, 1'b0, 32'd0, 4'b1111, 3'd4, 0);
    run_req("stride_misalign", 128'h2, 10'h100, 1'b1, 32'd6, 4'b1111, 3'd4, 0);
    run_req("vl0", 128'h3, 10'h100, 1'b0, 32'd0, 4'b1111, 3'd0, 0);
    run_req("vl7", 128'h87654321_FEDCBA98_76543210_01234567, 10'h200, 1'b0, 32'd0,
            4'b1111, 3'd7, 1);
    run_req("wrap", 128'h40404040_30303030_20202020_10101010, 10'h3F8, 1'b0, 32'd0,
            4'b1111, 3'd4, 0);
    run_req("mask0", 128'h5, 10'h080, 1'b0, 32'd0, 4'b0000, 3'd3, 0);

    // Reset during lane 1 while the memory is stalling.
    @(negedge clk);
    start_valid = 1'b1;
    vs3         = 128'h99999999_88888888_77777777_66666666;
    base_addr   = 10'h200;
    stride_en   = 1'b0;
    vmask       = 4'b1111;
    vl          = 3'd4;
    @(negedge clk);
    start_valid = 1'b0;
    mem_ready   = 1'b1;
    check("rstmid lane0_we", mem_we, 1);
    check("rstmid lane0_addr", mem_addr, 10'h200);
    @(negedge clk);
    mem_ready = 1'b0;
    check("rstmid lane1_addr", mem_addr, 10'h204);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid mem_we", mem_we, 0);
    check("rstmid busy", busy, 0);
    check("rstmid start_ready", start_ready, 1);
    check("rstmid done", done, 0);
    rst_n = 1'b1;
    run_req("after_rst", 128'hABCDEF01_23456789_0F1E2D3C_4B5A6978, 10'h010, 1'b1, 32'd12,
            4'b1111, 3'd4, 1);

    for (int k = 0; k < 25; k++) begin
      logic [AW-1:0] rb;
      logic [31:0]   rs;
      rb = AW'($urandom);
      if ($urandom_range(0, 7) != 0) rb[1:0] = 2'b00;
      rs = 32'($urandom_range(0, 64)) - 32'd32;
      if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
      run_req($sformatf("rand%0d", k), {$urandom, $urandom, $urandom, $urandom}, rb,
              1'($urandom), rs, NL'($urandom), 3'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
